// File: rtl/ovf_pkg.sv
// Shared types for the interval-buffer controller: FSM state encoding, record
// payload layout and default geometry.
package ovf_pkg;

  localparam int SIZE_DEF = 32;
  localparam int ADDR_W   = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CHECK,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
    logic              big;
  } rec_t;

endpackage

// File: rtl/ovf_buf_ctrl_if.sv
// Request/lookup/buffer signal bundle for ovf_buf_ctrl; slave is the controller.
// Statistics signals exist only when OVF_BUF_CTRL_STATS_EN is defined.
interface ovf_buf_ctrl_if;
  import ovf_pkg::*;

  logic [1:0]             rec_valid_i;
  logic [1:0]             rec_ready_o;
  logic [1:0][ADDR_W-1:0] rec_first_i;
  logic [1:0][ADDR_W-1:0] rec_last_i;
  logic [1:0]             rec_big_i;
  logic                   chk_valid_i;
  logic                   chk_ready_o;
  logic [ADDR_W-1:0]      chk_addr_i;
  logic                   clr_req_i;
  logic                   buf_en_write_o;
  logic                   buf_rst_us_o;
  logic                   buf_is_big_o;
  logic [ADDR_W-1:0]      buf_addr_first_o;
  logic [ADDR_W-1:0]      buf_addr_last_o;
  logic [ADDR_W-1:0]      buf_find_addr_o;
  logic                   buf_in_range_i;
  logic                   buf_is_first_i;
  logic                   chk_done_o;
  logic                   chk_hit_o;
  logic                   chk_first_o;
  logic                   rec_err_o;
  logic [CNT_W-1:0]       entries_o;
  logic                   wrap_o;
`ifdef OVF_BUF_CTRL_STATS_EN
  logic [31:0]            stat_writes_o;
  logic [31:0]            stat_hits_o;
`endif

  modport slave (
    input  rec_valid_i, rec_first_i, rec_last_i, rec_big_i,
    input  chk_valid_i, chk_addr_i, clr_req_i,
    input  buf_in_range_i, buf_is_first_i,
    output rec_ready_o, chk_ready_o,
    output buf_en_write_o, buf_rst_us_o, buf_is_big_o,
    output buf_addr_first_o, buf_addr_last_o, buf_find_addr_o,
    output chk_done_o, chk_hit_o, chk_first_o,
    output rec_err_o, entries_o, wrap_o
`ifdef OVF_BUF_CTRL_STATS_EN
    , output stat_writes_o, stat_hits_o
`endif
  );

  modport master (
    output rec_valid_i, rec_first_i, rec_last_i, rec_big_i,
    output chk_valid_i, chk_addr_i, clr_req_i,
    output buf_in_range_i, buf_is_first_i,
    input  rec_ready_o, chk_ready_o,
    input  buf_en_write_o, buf_rst_us_o, buf_is_big_o,
    input  buf_addr_first_o, buf_addr_last_o, buf_find_addr_o,
    input  chk_done_o, chk_hit_o, chk_first_o,
    input  rec_err_o, entries_o, wrap_o
`ifdef OVF_BUF_CTRL_STATS_EN
    , input stat_writes_o, stat_hits_o
`endif
  );

endinterface

// File: rtl/ovf_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer flips away from whoever was
// last granted and only moves when a grant is actually issued.
module ovf_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic pref_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (pref_q) begin
        if (req[1])      gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
      end else begin
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pref_q <= 1'b0;
    else if (gnt[0]) pref_q <= 1'b1;
    else if (gnt[1]) pref_q <= 1'b0;
  end

endmodule

// File: rtl/ovf_buf_ctrl.sv
// Controller in front of an interval buffer: arbitrates record writes, lookups
// and clears. Define OVF_BUF_CTRL_STATS_EN to add write/hit counters.
module ovf_buf_ctrl
  import ovf_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  ovf_buf_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  rec_t              rec_sel, rec_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        gnt;
  logic              clr_pend_q, err_q, done_q, hit_q, first_q, wrap_q;
  logic [CNT_W-1:0]  entries_q;
  logic              idle, clr_seen, rec_en, rec_take, rec_bad, chk_take;

  assign idle     = (state_q == ST_IDLE) & ~rst_i;
  assign clr_seen = bus.clr_req_i | clr_pend_q;
  assign chk_take = idle & ~clr_seen & bus.chk_valid_i;
  assign rec_en   = idle & ~clr_seen & ~bus.chk_valid_i;

  ovf_rr_arb2 u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .req (bus.rec_valid_i),
    .en  (rec_en),
    .gnt (gnt)
  );

  always_comb begin
    rec_sel       = '0;
    rec_sel.first = gnt[1] ? bus.rec_first_i[1] : bus.rec_first_i[0];
    rec_sel.last  = gnt[1] ? bus.rec_last_i[1]  : bus.rec_last_i[0];
    rec_sel.big   = gnt[1] ? bus.rec_big_i[1]   : bus.rec_big_i[0];
  end

  assign rec_take = |gnt;
  assign rec_bad  = rec_sel.first > rec_sel.last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_seen)                 state_d = ST_CLEAR;
        else if (chk_take)            state_d = ST_CHECK;
        else if (rec_take && !rec_bad) state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_CHECK: state_d = ST_IDLE;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // p0 -> p1: accepted request captured; lookup results sampled at end of CHECK
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rec_p1     <= '0;
      addr_p1    <= '0;
      clr_pend_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      first_q    <= 1'b0;
      entries_q  <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= rec_take & rec_bad;
      done_q  <= (state_q == ST_CHECK);
      if (rec_take) rec_p1  <= rec_sel;
      if (chk_take) addr_p1 <= bus.chk_addr_i;
      // A clear that shows up mid-operation must survive until IDLE
      if (state_q == ST_CLEAR)
        clr_pend_q <= 1'b0;
      else if (bus.clr_req_i && (state_q == ST_WRITE || state_q == ST_CHECK))
        clr_pend_q <= 1'b1;
      case (state_q)
        ST_CHECK: begin
          hit_q   <= bus.buf_in_range_i;
          first_q <= bus.buf_is_first_i;
        end
        ST_WRITE: begin
          if (entries_q == CNT_W'(SIZE)) wrap_q <= 1'b1;
          else                           entries_q <= entries_q + 1'b1;
        end
        ST_CLEAR: begin
          entries_q <= '0;
          wrap_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef OVF_BUF_CTRL_STATS_EN
  logic [31:0] stat_wr_q, stat_hit_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_wr_q  <= '0;
      stat_hit_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      stat_wr_q  <= '0;
      stat_hit_q <= '0;
    end else begin
      if (state_q == ST_WRITE) stat_wr_q <= sat_inc32(stat_wr_q);
      if (state_q == ST_CHECK && bus.buf_in_range_i) stat_hit_q <= sat_inc32(stat_hit_q);
    end
  end

  assign bus.stat_writes_o = stat_wr_q;
  assign bus.stat_hits_o   = stat_hit_q;
`endif

  assign bus.rec_ready_o      = gnt;
  assign bus.chk_ready_o      = chk_take;
  assign bus.buf_en_write_o   = (state_q == ST_WRITE);
  assign bus.buf_rst_us_o     = (state_q == ST_CLEAR);
  assign bus.buf_is_big_o     = rec_p1.big;
  assign bus.buf_addr_first_o = rec_p1.first;
  assign bus.buf_addr_last_o  = rec_p1.last;
  assign bus.buf_find_addr_o  = addr_p1;
  assign bus.chk_done_o       = done_q;
  assign bus.chk_hit_o        = hit_q;
  assign bus.chk_first_o      = first_q;
  assign bus.rec_err_o        = err_q;
  assign bus.entries_o        = entries_q;
  assign bus.wrap_o           = wrap_q;

endmodule

// File: tb/tb_ovf_buf_ctrl.sv
// Directed bench for ovf_buf_ctrl: inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge against hand-computed values.
module tb_ovf_buf_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   k0, k1;

  always #5 clk = ~clk;

  ovf_buf_ctrl_if bus ();

  ovf_buf_ctrl #(.SIZE(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_rec(input int r, input logic [31:0] f, input logic [31:0] l, input logic b);
    bus.rec_first_i[r] = f;
    bus.rec_last_i[r]  = l;
    bus.rec_big_i[r]   = b;
  endtask

  initial begin
    bus.rec_valid_i    = 2'b01;
    bus.rec_first_i    = '0;
    bus.rec_last_i     = '0;
    bus.rec_big_i      = '0;
    bus.chk_valid_i    = 1'b1;
    bus.chk_addr_i     = '0;
    bus.clr_req_i      = 1'b0;
    bus.buf_in_range_i = 1'b0;
    bus.buf_is_first_i = 1'b0;

    // Reset state, with requests pending that must not be accepted
    repeat (2) @(posedge clk);
    smp();
    chk("rst_rec_ready", 64'(bus.rec_ready_o), 64'd0);
    chk("rst_chk_ready", 64'(bus.chk_ready_o), 64'd0);
    chk("rst_en_write", 64'(bus.buf_en_write_o), 64'd0);
    chk("rst_rst_us", 64'(bus.buf_rst_us_o), 64'd0);
    chk("rst_entries", 64'(bus.entries_o), 64'd0);
    chk("rst_wrap", 64'(bus.wrap_o), 64'd0);
    chk("rst_chk_done", 64'(bus.chk_done_o), 64'd0);
    step();
    bus.rec_valid_i = 2'b00;
    bus.chk_valid_i = 1'b0;
    rst = 1'b0;

    // Single record from r0
    step();
    set_rec(0, 32'h100, 32'h1FF, 1'b0);
    bus.rec_valid_i = 2'b01;
    smp();
    chk("t1_ready", 64'(bus.rec_ready_o), 64'd1);
    chk("t1_no_early_write", 64'(bus.buf_en_write_o), 64'd0);
    step();
    bus.rec_valid_i = 2'b00;
    smp();
    chk("t1_write", 64'(bus.buf_en_write_o), 64'd1);
    chk("t1_first", 64'(bus.buf_addr_first_o), 64'h100);
    chk("t1_last", 64'(bus.buf_addr_last_o), 64'h1FF);
    chk("t1_big", 64'(bus.buf_is_big_o), 64'd0);
    chk("t1_ready_in_write", 64'(bus.rec_ready_o), 64'd0);
    step();
    smp();
    chk("t1_write_done", 64'(bus.buf_en_write_o), 64'd0);
    chk("t1_entries", 64'(bus.entries_o), 64'd1);

    // Round-robin with both requesters, pointer back at r0 after reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    k0 = 0;
    k1 = 0;
    set_rec(0, 32'h1000, 32'h100F, 1'b0);
    set_rec(1, 32'h2000, 32'h200F, 1'b1);
    bus.rec_valid_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("t2_grant", 64'(bus.rec_ready_o), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t2_idle_no_write", 64'(bus.buf_en_write_o), 64'd0);
      step();
      if (i % 2 == 0) begin
        k0++;
        set_rec(0, 32'h1000 + 32'(k0 * 16), 32'h100F + 32'(k0 * 16), 1'b0);
        if (k0 == 4) bus.rec_valid_i[0] = 1'b0;
      end else begin
        k1++;
        set_rec(1, 32'h2000 + 32'(k1 * 16), 32'h200F + 32'(k1 * 16), 1'b1);
        if (k1 == 4) bus.rec_valid_i[1] = 1'b0;
      end
      smp();
      chk("t2_write", 64'(bus.buf_en_write_o), 64'd1);
      chk("t2_gap_ready", 64'(bus.rec_ready_o), 64'd0);
      chk("t2_first", 64'(bus.buf_addr_first_o),
          64'(((i % 2 == 0) ? 32'h1000 : 32'h2000) + 32'((i / 2) * 16)));
      chk("t2_big", 64'(bus.buf_is_big_o), (i % 2 == 0) ? 64'd0 : 64'd1);
      step();
    end
    smp();
    chk("t2_entries", 64'(bus.entries_o), 64'd8);

    // Lookup hit, then lookup miss
    step();
    bus.chk_valid_i    = 1'b1;
    bus.chk_addr_i     = 32'h150;
    bus.buf_in_range_i = 1'b1;
    bus.buf_is_first_i = 1'b0;
    smp();
    chk("t3_chk_ready", 64'(bus.chk_ready_o), 64'd1);
    step();
    bus.chk_valid_i = 1'b0;
    smp();
    chk("t3_find_addr", 64'(bus.buf_find_addr_o), 64'h150);
    chk("t3_done_early", 64'(bus.chk_done_o), 64'd0);
    step();
    smp();
    chk("t3_done", 64'(bus.chk_done_o), 64'd1);
    chk("t3_hit", 64'(bus.chk_hit_o), 64'd1);
    chk("t3_first", 64'(bus.chk_first_o), 64'd0);
    step();
    smp();
    chk("t3_done_pulse", 64'(bus.chk_done_o), 64'd0);
    chk("t3_hit_held", 64'(bus.chk_hit_o), 64'd1);
    step();
    bus.chk_valid_i    = 1'b1;
    bus.chk_addr_i     = 32'h40;
    bus.buf_in_range_i = 1'b0;
    bus.buf_is_first_i = 1'b1;
    smp();
    chk("t3b_chk_ready", 64'(bus.chk_ready_o), 64'd1);
    step();
    bus.chk_valid_i = 1'b0;
    step();
    smp();
    chk("t3b_done", 64'(bus.chk_done_o), 64'd1);
    chk("t3b_hit", 64'(bus.chk_hit_o), 64'd0);
    chk("t3b_first", 64'(bus.chk_first_o), 64'd1);

    // 33 writes into a 32-entry buffer, then clear
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_rec(0, 32'h100, 32'h1FF, 1'b0);
    bus.rec_valid_i = 2'b01;
    for (int i = 0; i < 33; i++) begin
      smp();
      if (i == 32) begin
        chk("t4_entries_32", 64'(bus.entries_o), 64'd32);
        chk("t4_no_wrap_yet", 64'(bus.wrap_o), 64'd0);
      end
      chk("t4_ready", 64'(bus.rec_ready_o), 64'd1);
      step();
      if (i == 32) bus.rec_valid_i = 2'b00;
      step();
    end
    smp();
    chk("t4_entries_sat", 64'(bus.entries_o), 64'd32);
    chk("t4_wrap", 64'(bus.wrap_o), 64'd1);
    step();
    bus.clr_req_i = 1'b1;
    smp();
    chk("t4_rst_us_early", 64'(bus.buf_rst_us_o), 64'd0);
    step();
    bus.clr_req_i = 1'b0;
    smp();
    chk("t4_rst_us", 64'(bus.buf_rst_us_o), 64'd1);
    step();
    smp();
    chk("t4_rst_us_pulse", 64'(bus.buf_rst_us_o), 64'd0);
    chk("t4_entries_clr", 64'(bus.entries_o), 64'd0);
    chk("t4_wrap_clr", 64'(bus.wrap_o), 64'd0);

    // Inverted interval is rejected
    step();
    set_rec(0, 32'h200, 32'h100, 1'b0);
    bus.rec_valid_i = 2'b01;
    smp();
    chk("t5_ready", 64'(bus.rec_ready_o), 64'd1);
    step();
    bus.rec_valid_i = 2'b00;
    smp();
    chk("t5_err", 64'(bus.rec_err_o), 64'd1);
    chk("t5_no_write", 64'(bus.buf_en_write_o), 64'd0);
    step();
    smp();
    chk("t5_err_pulse", 64'(bus.rec_err_o), 64'd0);
    chk("t5_entries", 64'(bus.entries_o), 64'd0);

    // Clear beats a simultaneous check; clear raised during CHECK is deferred
    step();
    bus.clr_req_i      = 1'b1;
    bus.chk_valid_i    = 1'b1;
    bus.chk_addr_i     = 32'h150;
    bus.buf_in_range_i = 1'b1;
    bus.buf_is_first_i = 1'b1;
    smp();
    chk("t5_chk_blocked", 64'(bus.chk_ready_o), 64'd0);
    step();
    bus.clr_req_i = 1'b0;
    smp();
    chk("t5_clear_first", 64'(bus.buf_rst_us_o), 64'd1);
    chk("t5_chk_wait", 64'(bus.chk_ready_o), 64'd0);
    step();
    smp();
    chk("t5_chk_after_clr", 64'(bus.chk_ready_o), 64'd1);
    step();
    bus.chk_valid_i = 1'b0;
    bus.clr_req_i   = 1'b1;
    smp();
    chk("t5_no_clr_in_check", 64'(bus.buf_rst_us_o), 64'd0);
    chk("t5_find_addr", 64'(bus.buf_find_addr_o), 64'h150);
    step();
    bus.clr_req_i = 1'b0;
    smp();
    chk("t5_done", 64'(bus.chk_done_o), 64'd1);
    chk("t5_pend_idle", 64'(bus.buf_rst_us_o), 64'd0);
    step();
    smp();
    chk("t5_pend_clear", 64'(bus.buf_rst_us_o), 64'd1);
    step();
    smp();
    chk("t5_pend_once", 64'(bus.buf_rst_us_o), 64'd0);
    chk("t5_hit_held", 64'(bus.chk_hit_o), 64'd1);

    // Reset asserted in the middle of a WRITE cycle
    step();
    set_rec(0, 32'h300, 32'h3FF, 1'b1);
    bus.rec_valid_i = 2'b01;
    smp();
    chk("t6_ready", 64'(bus.rec_ready_o), 64'd1);
    step();
    bus.rec_valid_i = 2'b00;
    smp();
    chk("t6_write", 64'(bus.buf_en_write_o), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_write_abort", 64'(bus.buf_en_write_o), 64'd0);
    chk("t6_first_zero", 64'(bus.buf_addr_first_o), 64'd0);
    chk("t6_last_zero", 64'(bus.buf_addr_last_o), 64'd0);
    chk("t6_big_zero", 64'(bus.buf_is_big_o), 64'd0);
    chk("t6_hit_zero", 64'(bus.chk_hit_o), 64'd0);
    chk("t6_first_flag_zero", 64'(bus.chk_first_o), 64'd0);
    chk("t6_entries_zero", 64'(bus.entries_o), 64'd0);
    chk("t6_rst_us_zero", 64'(bus.buf_rst_us_o), 64'd0);
    step();
    rst = 1'b0;
    step();
    smp();
    chk("t6_no_write_after", 64'(bus.buf_en_write_o), 64'd0);
    chk("t6_entries_after", 64'(bus.entries_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
